// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCredit = 2'd1,
    StVend   = 2'd2,
    StChange = 2'd3
  } vend_state_e;

  localparam logic [1:0] CoinNickel  = 2'd0;
  localparam logic [1:0] CoinDime    = 2'd1;
  localparam logic [1:0] CoinQuarter = 2'd2;
  localparam logic [1:0] CoinForeign = 2'd3;

  localparam int unsigned CoinValW = 8;

  // Credit value of a coin code; foreign coins are worth nothing.
  function automatic logic [CoinValW-1:0] coin_value(input logic [1:0] code);
    logic [CoinValW-1:0] val;
    val = '0;
    unique case (code)
      CoinNickel:  val = 8'd5;
      CoinDime:    val = 8'd10;
      CoinQuarter: val = 8'd25;
      default:     val = 8'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vending_stock.sv
// Per-item stock counter: reload on reset/restock, saturating decrement.
module vending_stock
  import vending_pkg::*;
#(
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic dec,
  output logic zero
);

  logic [STOCK_W-1:0] count_q;

  // Count state; the zero guard keeps the counter from wrapping.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      count_q <= STOCK_W'(INIT_STOCK);
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: coin credit, selection check, vend pulse, change return.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned PRICE      = 15,
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 5,
  localparam int unsigned ITEM_W    = $clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_valid,
  input  logic [1:0]           coin_code,
  input  logic                 sel_valid,
  input  logic [ITEM_W-1:0]    sel_item,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 vend_valid,
  output logic [ITEM_W-1:0]    vend_item,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_amt,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 coin_reject,
  output logic                 sel_err,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  vend_state_e          state_q;
  logic [NUM_ITEMS-1:0] stock_zero;
  logic [NUM_ITEMS-1:0] stock_dec;
  logic                 stock_reload;
  logic [CREDIT_W:0]    coin_sum;
  logic                 coin_fits;
  logic                 sel_ok;
  logic                 sel_accept;

  // Decode coin arithmetic, selection acceptance and stock strobes.
  always_comb begin
    coin_sum     = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_code));
    coin_fits    = !coin_sum[CREDIT_W] && (coin_code != CoinForeign);
    sel_ok       = (32'(sel_item) < NUM_ITEMS) && !stock_zero[sel_item] &&
                   (credit >= CREDIT_W'(PRICE));
    // Cancel outranks selection in CREDIT, so a cancelled cycle never vends.
    sel_accept   = (state_q == StCredit) && !cancel && sel_valid && sel_ok;
    stock_reload = (state_q == StIdle) && restock;
    stock_dec    = '0;
    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
      stock_dec[i] = sel_accept && (32'(sel_item) == i);
    end
  end

  for (genvar g = 0; g < int'(NUM_ITEMS); g++) begin : g_stock
    vending_stock #(
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK)
    ) u_stock (
      .clk    (clk),
      .rst    (rst),
      .reload (stock_reload),
      .dec    (stock_dec[g]),
      .zero   (stock_zero[g])
    );
  end

  // Main FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      credit       <= '0;
      vend_valid   <= 1'b0;
      vend_item    <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      busy         <= 1'b0;
      sold_out     <= {NUM_ITEMS{INIT_STOCK == 0}};
    end else begin
      vend_valid   <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      busy         <= 1'b0;
      sold_out     <= stock_zero;
      unique case (state_q)
        StIdle: begin
          if (sel_valid) sel_err <= 1'b1;
          if (coin_valid) begin
            if (coin_fits) begin
              credit  <= coin_sum[CREDIT_W-1:0];
              state_q <= StCredit;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        StCredit: begin
          if (cancel) begin
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
            busy         <= 1'b1;
            state_q      <= StChange;
          end else if (sel_valid) begin
            if (sel_ok) begin
              vend_valid <= 1'b1;
              vend_item  <= sel_item;
              credit     <= credit - CREDIT_W'(PRICE);
              busy       <= 1'b1;
              state_q    <= StVend;
            end else begin
              sel_err <= 1'b1;
            end
          end else if (coin_valid && coin_fits) begin
            credit <= coin_sum[CREDIT_W-1:0];
          end
          // Any coin not credited above is handed back.
          if (coin_valid && (cancel || sel_valid || !coin_fits)) coin_reject <= 1'b1;
        end
        StVend: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (sel_valid) sel_err <= 1'b1;
          if (credit != '0) begin
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
            busy         <= 1'b1;
            state_q      <= StChange;
          end else begin
            state_q <= StIdle;
          end
        end
        StChange: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (sel_valid) sel_err <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench: default, single-stock and narrow-credit controllers side by side.
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;

  logic       a_vend_valid, a_change_valid, a_coin_reject, a_sel_err, a_busy;
  logic [1:0] a_vend_item;
  logic [7:0] a_change_amt, a_credit;
  logic [3:0] a_sold_out;

  logic       b_vend_valid, b_change_valid, b_coin_reject, b_sel_err, b_busy;
  logic [1:0] b_vend_item;
  logic [7:0] b_change_amt, b_credit;
  logic [3:0] b_sold_out;

  logic       c_vend_valid, c_change_valid, c_coin_reject, c_sel_err, c_busy;
  logic [1:0] c_vend_item;
  logic [4:0] c_change_amt, c_credit;
  logic [3:0] c_sold_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vending_ctrl u_a (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_code(coin_code),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .restock(restock),
    .vend_valid(a_vend_valid), .vend_item(a_vend_item), .change_valid(a_change_valid),
    .change_amt(a_change_amt), .credit(a_credit), .coin_reject(a_coin_reject),
    .sel_err(a_sel_err), .sold_out(a_sold_out), .busy(a_busy)
  );

  vending_ctrl #(.INIT_STOCK(1)) u_b (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_code(coin_code),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .restock(restock),
    .vend_valid(b_vend_valid), .vend_item(b_vend_item), .change_valid(b_change_valid),
    .change_amt(b_change_amt), .credit(b_credit), .coin_reject(b_coin_reject),
    .sel_err(b_sel_err), .sold_out(b_sold_out), .busy(b_busy)
  );

  vending_ctrl #(.CREDIT_W(5)) u_c (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_code(coin_code),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel), .restock(restock),
    .vend_valid(c_vend_valid), .vend_item(c_vend_item), .change_valid(c_change_valid),
    .change_amt(c_change_amt), .credit(c_credit), .coin_reject(c_coin_reject),
    .sel_err(c_sel_err), .sold_out(c_sold_out), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_code  = code;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input logic [1:0] item);
    sel_valid = 1'b1;
    sel_item  = item;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    tick();
    chk("rst_credit", 32'(a_credit), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_vend", 32'(a_vend_valid), 0);
    chk("rst_sold_out", 32'(a_sold_out), 0);
    rst = 1'b0;

    // 10 + 10, buy item 2, change of 5
    coin(2'd1);
    chk("a_credit_10", 32'(a_credit), 10);
    coin(2'd1);
    chk("a_credit_20", 32'(a_credit), 20);
    sel(2'd2);
    chk("a_vend_valid", 32'(a_vend_valid), 1);
    chk("a_vend_item", 32'(a_vend_item), 2);
    chk("a_busy_vend", 32'(a_busy), 1);
    chk("a_no_change_yet", 32'(a_change_valid), 0);
    tick();
    chk("a_change_valid", 32'(a_change_valid), 1);
    chk("a_change_amt", 32'(a_change_amt), 5);
    chk("a_credit_zero", 32'(a_credit), 0);
    chk("a_vend_drop", 32'(a_vend_valid), 0);
    tick();
    chk("a_change_drop", 32'(a_change_valid), 0);
    chk("a_change_amt_0", 32'(a_change_amt), 0);
    chk("a_busy_idle", 32'(a_busy), 0);

    // Four more item-2 buys with exact money drain its stock of 4
    for (int k = 0; k < 4; k++) begin
      coin(2'd1);
      coin(2'd0);
      sel(2'd2);
      chk("a_drain_vend", 32'(a_vend_valid), 1);
      tick();
      chk("a_drain_nochange", 32'(a_change_valid), 0);
    end
    chk("a_sold_out_2", 32'(a_sold_out), 4'b0100);
    coin(2'd2);
    sel(2'd2);
    chk("a_soldout_err", 32'(a_sel_err), 1);
    chk("a_soldout_novend", 32'(a_vend_valid), 0);
    chk("a_soldout_credit", 32'(a_credit), 25);

    // Cancel refunds full credit
    do_cancel();
    chk("a_cancel_change", 32'(a_change_valid), 1);
    chk("a_cancel_amt", 32'(a_change_amt), 25);
    chk("a_cancel_novend", 32'(a_vend_valid), 0);
    tick();
    chk("a_cancel_idle_busy", 32'(a_busy), 0);
    chk("a_cancel_idle_credit", 32'(a_credit), 0);

    // Foreign coin in IDLE, then restock clears sold_out a cycle later
    coin(2'd3);
    chk("a_foreign_reject", 32'(a_coin_reject), 1);
    chk("a_foreign_credit", 32'(a_credit), 0);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    tick();
    chk("a_restock_sold_out", 32'(a_sold_out), 0);

    // INIT_STOCK=1: second buy of item 0 refused, credit kept, then refunded
    do_reset();
    coin(2'd1);
    coin(2'd1);
    sel(2'd0);
    chk("b_vend1", 32'(b_vend_valid), 1);
    tick();
    chk("b_change1", 32'(b_change_amt), 5);
    tick();
    chk("b_sold_out", 32'(b_sold_out), 4'b0001);
    coin(2'd2);
    sel(2'd0);
    chk("b_sel_err", 32'(b_sel_err), 1);
    chk("b_novend", 32'(b_vend_valid), 0);
    chk("b_credit_kept", 32'(b_credit), 25);
    do_cancel();
    chk("b_refund_valid", 32'(b_change_valid), 1);
    chk("b_refund_amt", 32'(b_change_amt), 25);
    tick();

    // CREDIT_W=5: 25 + 10 overflows, foreign coin rejected
    do_reset();
    coin(2'd2);
    chk("c_credit_25", 32'(c_credit), 25);
    coin(2'd1);
    chk("c_overflow_reject", 32'(c_coin_reject), 1);
    chk("c_overflow_credit", 32'(c_credit), 25);
    chk("a_credit_35", 32'(a_credit), 35);
    coin(2'd3);
    chk("c_foreign_reject", 32'(c_coin_reject), 1);
    chk("c_foreign_credit", 32'(c_credit), 25);
    do_cancel();
    tick();

    // Cancel + sel + coin together: refund wins, coin bounced
    do_reset();
    coin(2'd2);
    cancel     = 1'b1;
    sel_valid  = 1'b1;
    sel_item   = 2'd1;
    coin_valid = 1'b1;
    coin_code  = 2'd0;
    tick();
    cancel     = 1'b0;
    sel_valid  = 1'b0;
    coin_valid = 1'b0;
    chk("mix_change", 32'(a_change_valid), 1);
    chk("mix_amt", 32'(a_change_amt), 25);
    chk("mix_novend", 32'(a_vend_valid), 0);
    chk("mix_reject", 32'(a_coin_reject), 1);
    chk("mix_no_sel_err", 32'(a_sel_err), 0);
    tick();

    // Reset during VEND squashes the change and restores stock
    do_reset();
    coin(2'd1);
    coin(2'd1);
    sel(2'd0);
    chk("b_pre_rst_vend", 32'(b_vend_valid), 1);
    do_reset();
    chk("b_rst_vend", 32'(b_vend_valid), 0);
    chk("b_rst_change", 32'(b_change_valid), 0);
    chk("b_rst_credit", 32'(b_credit), 0);
    chk("b_rst_busy", 32'(b_busy), 0);
    tick();
    chk("b_rst_nochange", 32'(b_change_valid), 0);
    chk("b_rst_sold_out", 32'(b_sold_out), 0);
    coin(2'd1);
    coin(2'd1);
    sel(2'd0);
    chk("b_restored_vend", 32'(b_vend_valid), 1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
